// File: rtl/key_evt_pkg.sv
// Shared types and sizing helpers for the multi-key event detector.
package key_evt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  function automatic int cnt_w(input int long_t, input int rep_t);
    return $clog2(((long_t > rep_t) ? long_t : rep_t) + 1);
  endfunction

endpackage

// File: rtl/key_event_chan.sv
// One key channel: edge detect, hold counter and press/long/repeat/release FSM.
module key_event_chan
  import key_evt_pkg::*;
#(
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 25
) (
  input  logic clk_100Hz,
  input  logic rst_n,
  input  logic i_key,
  input  logic i_repeat_en,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat,
  output logic o_held,
  output logic o_evt_nxt
);

  localparam int CW = cnt_w(LONG_TICKS, REPEAT_TICKS);

  state_t          r_state, w_state_nxt;
  logic            r_key_dly;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_press, w_release, w_long, w_repeat;

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_key_dly <= 1'b0;
      r_cnt     <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
      o_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_key_dly <= i_key;
      r_cnt     <= w_cnt_nxt;
      o_press   <= w_press;
      o_release <= w_release;
      o_long    <= w_long;
      o_repeat  <= w_repeat;
      o_held    <= (w_state_nxt != IDLE);
    end
  end

  // Release is checked first in PRESS/LONG so it pre-empts long/repeat.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_key && !r_key_dly) begin
          w_press     = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = PRESS;
        end
      end
      PRESS: begin
        if (!i_key) begin
          w_release   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (r_cnt == CW'(LONG_TICKS)) begin
          w_long      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = LONG;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      LONG: begin
        if (!i_key) begin
          w_release   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (!i_repeat_en) begin
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(REPEAT_TICKS - 1)) begin
          w_repeat    = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_evt_nxt = w_press | w_release | w_long | w_repeat;

endmodule

// File: rtl/key_event_detector.sv
// Multi-key event detector: N_KEYS independent channels plus a combined event flag.
module key_event_detector
  import key_evt_pkg::*;
#(
  parameter int N_KEYS       = 5,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 25
) (
  input  logic              clk_100Hz,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic [N_KEYS-1:0] held,
  output logic              any_event
);

  logic [N_KEYS-1:0] w_evt_nxt;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_event_chan #(
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_chan (
      .clk_100Hz   (clk_100Hz),
      .rst_n       (rst_n),
      .i_key       (key_in[g]),
      .i_repeat_en (repeat_en[g]),
      .o_press     (press_pulse[g]),
      .o_release   (release_pulse[g]),
      .o_long      (long_pulse[g]),
      .o_repeat    (repeat_pulse[g]),
      .o_held      (held[g]),
      .o_evt_nxt   (w_evt_nxt[g])
    );
  end

  // Registered from the channels' next-values so it lines up with the pulses.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) any_event <= 1'b0;
    else        any_event <= |w_evt_nxt;
  end

endmodule

// File: tb/tb_key_event_detector.sv
// Directed bench for key_event_detector with hand-computed per-cycle expectations.
module tb_key_event_detector;

  logic       clk_100Hz = 1'b0;
  logic       rst_n;
  logic [4:0] key_in;
  logic [4:0] repeat_en;
  logic [4:0] press_pulse, release_pulse, long_pulse, repeat_pulse, held;
  logic       any_event;

  int checks = 0;
  int errors = 0;

  key_event_detector #(.N_KEYS(5), .LONG_TICKS(100), .REPEAT_TICKS(25)) dut (
    .clk_100Hz     (clk_100Hz),
    .rst_n         (rst_n),
    .key_in        (key_in),
    .repeat_en     (repeat_en),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .any_event     (any_event)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] ep, input logic [4:0] er,
                         input logic [4:0] el, input logic [4:0] erp, input logic [4:0] eh);
    chk({tag, ".press"},   press_pulse,   ep);
    chk({tag, ".release"}, release_pulse, er);
    chk({tag, ".long"},    long_pulse,    el);
    chk({tag, ".repeat"},  repeat_pulse,  erp);
    chk({tag, ".held"},    held,          eh);
    chk({tag, ".any"},     {4'b0, any_event}, {4'b0, |{ep, er, el, erp}});
  endtask

  // Advance one edge, sample 1 time unit later, compare everything.
  task automatic cyc(input string tag, input logic [4:0] ep, input logic [4:0] er,
                     input logic [4:0] el, input logic [4:0] erp, input logic [4:0] eh);
    @(posedge clk_100Hz);
    #1;
    chk_all(tag, ep, er, el, erp, eh);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_in    = 5'b0;
    repeat_en = 5'b0;
    #1;
    chk_all("reset", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    cyc("reset_clk", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    rst_n = 1'b1;
    cyc("idle", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // 1: short press on key0
    key_in = 5'b00001;
    cyc("t1_press", 5'b00001, 5'b0, 5'b0, 5'b0, 5'b00001);
    repeat (4) cyc("t1_hold", 5'b0, 5'b0, 5'b0, 5'b0, 5'b00001);
    key_in = 5'b0;
    cyc("t1_rel", 5'b0, 5'b00001, 5'b0, 5'b0, 5'b0);
    cyc("t1_idle", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // 2: key1 long hold with auto-repeat
    repeat_en = 5'b00010;
    key_in    = 5'b00010;
    cyc("t2_press", 5'b00010, 5'b0, 5'b0, 5'b0, 5'b00010);
    repeat (99) cyc("t2_hold", 5'b0, 5'b0, 5'b0, 5'b0, 5'b00010);
    cyc("t2_long", 5'b0, 5'b0, 5'b00010, 5'b0, 5'b00010);
    repeat (24) cyc("t2_wait1", 5'b0, 5'b0, 5'b0, 5'b0, 5'b00010);
    cyc("t2_rpt1", 5'b0, 5'b0, 5'b0, 5'b00010, 5'b00010);
    repeat (24) cyc("t2_wait2", 5'b0, 5'b0, 5'b0, 5'b0, 5'b00010);
    cyc("t2_rpt2", 5'b0, 5'b0, 5'b0, 5'b00010, 5'b00010);
    repeat (9) cyc("t2_wait3", 5'b0, 5'b0, 5'b0, 5'b0, 5'b00010);
    key_in = 5'b0;
    cyc("t2_rel", 5'b0, 5'b00010, 5'b0, 5'b0, 5'b0);
    repeat_en = 5'b0;

    // 3: key2 long hold, repeat disabled
    key_in = 5'b00100;
    cyc("t3_press", 5'b00100, 5'b0, 5'b0, 5'b0, 5'b00100);
    repeat (99) cyc("t3_hold", 5'b0, 5'b0, 5'b0, 5'b0, 5'b00100);
    cyc("t3_long", 5'b0, 5'b0, 5'b00100, 5'b0, 5'b00100);
    repeat (29) cyc("t3_norpt", 5'b0, 5'b0, 5'b0, 5'b0, 5'b00100);
    key_in = 5'b0;
    cyc("t3_rel", 5'b0, 5'b00100, 5'b0, 5'b0, 5'b0);

    // 4: key3 released exactly on the long-press edge
    key_in = 5'b01000;
    cyc("t4_press", 5'b01000, 5'b0, 5'b0, 5'b0, 5'b01000);
    repeat (99) cyc("t4_hold", 5'b0, 5'b0, 5'b0, 5'b0, 5'b01000);
    key_in = 5'b0;
    cyc("t4_rel", 5'b0, 5'b01000, 5'b0, 5'b0, 5'b0);
    cyc("t4_nolong", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // 5: simultaneous presses, key0 glitches 1-0-1
    key_in = 5'b10001;
    cyc("t5_press", 5'b10001, 5'b0, 5'b0, 5'b0, 5'b10001);
    key_in = 5'b10000;
    cyc("t5_glitch_rel", 5'b0, 5'b00001, 5'b0, 5'b0, 5'b10000);
    key_in = 5'b10001;
    cyc("t5_repress", 5'b00001, 5'b0, 5'b0, 5'b0, 5'b10001);
    cyc("t5_hold", 5'b0, 5'b0, 5'b0, 5'b0, 5'b10001);
    key_in = 5'b0;
    cyc("t5_rel", 5'b0, 5'b10001, 5'b0, 5'b0, 5'b0);
    cyc("t5_idle", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // 6: key held across reset release, then reset again mid-hold
    rst_n  = 1'b0;
    key_in = 5'b00001;
    #1;
    chk_all("t6_in_reset", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    repeat (2) cyc("t6_reset_hold", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    rst_n = 1'b1;
    cyc("t6_press", 5'b00001, 5'b0, 5'b0, 5'b0, 5'b00001);
    repeat (49) cyc("t6_hold", 5'b0, 5'b0, 5'b0, 5'b0, 5'b00001);
    rst_n = 1'b0;
    #1;
    chk_all("t6_midreset", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    cyc("t6_midreset_clk", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    rst_n = 1'b1;
    cyc("t6_repress", 5'b00001, 5'b0, 5'b0, 5'b0, 5'b00001);
    repeat (60) cyc("t6_nolong", 5'b0, 5'b0, 5'b0, 5'b0, 5'b00001);
    key_in = 5'b0;
    cyc("t6_rel", 5'b0, 5'b00001, 5'b0, 5'b0, 5'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
